// File: rtl/hdc_pkg.sv
// hdc_pkg: shared constants, types and search FSM states for the HDC inference path.
package hdc_pkg;
    localparam int HV_DIM          = 4096;
    localparam int SEQ_CYCLE_COUNT = 4;
    localparam int DIMS_PER_CC     = HV_DIM / SEQ_CYCLE_COUNT;
    localparam int NUM_CLASSES     = 26;
    localparam int DIST_W          = $clog2(HV_DIM) + 1;
    localparam int POP_W           = $clog2(DIMS_PER_CC) + 1;
    localparam int CHUNK_W         = $clog2(SEQ_CYCLE_COUNT);
    typedef logic [DIST_W-1:0] dist_t;
    typedef logic [4:0] class_idx_t;
    typedef logic [POP_W-1:0] pop_t;
    typedef logic [CHUNK_W-1:0] chunk_idx_t;
    localparam chunk_idx_t LAST_CHUNK = chunk_idx_t'(SEQ_CYCLE_COUNT - 1);
    localparam class_idx_t LAST_CLASS = class_idx_t'(NUM_CLASSES - 1);
    typedef enum logic [1:0] {IDLE, COMPARE, DRAIN, DONE} search_state_t;
endpackage

// File: rtl/hv_chunk_popcount.sv
// hv_chunk_popcount: Hamming distance of two DIMS_PER_CC-bit chunks (XOR + two-level adder tree).
module hv_chunk_popcount
    import hdc_pkg::*;
(
    input  logic [DIMS_PER_CC-1:0] i_a,
    input  logic [DIMS_PER_CC-1:0] i_b,
    output pop_t                   o_cnt
);
    localparam int GRP  = 32;
    localparam int NGRP = DIMS_PER_CC / GRP;
    logic [DIMS_PER_CC-1:0] w_diff;
    logic [5:0]             w_grp [NGRP];
    assign w_diff = i_a ^ i_b;
    always_comb begin
        o_cnt = '0;
        for (int g = 0; g < NGRP; g++) begin
            w_grp[g] = '0;
            for (int b = 0; b < GRP; b++) w_grp[g] = w_grp[g] + 6'(w_diff[g*GRP+b]);
            o_cnt = o_cnt + pop_t'(w_grp[g]);
        end
    end
endmodule

// File: rtl/class_hv_search.sv
// class_hv_search: nearest-class search by Hamming distance over NUM_CLASSES binary class HVs.
// Optional CLASS_MASK_EN adds a per-class eligibility mask and a no_valid_class flag.
module class_hv_search
    import hdc_pkg::*;
(
    input  logic                                        clk,
    input  logic                                        rst,
    input  logic                                        en,
    input  logic                                        start_search,
    input  logic [HV_DIM-1:0]                           query_hv,
    input  logic [SEQ_CYCLE_COUNT-1:0][DIMS_PER_CC-1:0] bin_class_hvs [0:NUM_CLASSES-1],
`ifdef CLASS_MASK_EN
    input  logic [NUM_CLASSES-1:0]                      class_valid_mask,
    output logic                                        no_valid_class,
`endif
    output logic                                        busy,
    output logic                                        search_done,
    output logic [4:0]                                  predicted_class,
    output logic [DIST_W-1:0]                           min_distance
);
    search_state_t r_state, w_next;
    logic [SEQ_CYCLE_COUNT-1:0][DIMS_PER_CC-1:0] r_query;
    chunk_idx_t r_chunk;
    class_idx_t r_cls, r_pop_cls, r_best_cls;
    pop_t       r_pop, w_pop;
    logic       r_pop_vld, r_pop_last;
    dist_t      r_acc, r_best_dist, w_cand;
    logic       w_elig, w_upd, w_last_issue, w_accept;

    hv_chunk_popcount u_pop (
        .i_a   (r_query[r_chunk]),
        .i_b   (bin_class_hvs[r_cls][r_chunk]),
        .o_cnt (w_pop)
    );

`ifdef CLASS_MASK_EN
    logic [NUM_CLASSES-1:0] r_mask;
    assign w_elig = r_mask[r_pop_cls];
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mask         <= '0;
            no_valid_class <= 1'b0;
        end else if (en) begin
            if (w_accept) r_mask <= class_valid_mask;
            if (r_state == DRAIN) no_valid_class <= ~|r_mask;
        end
    end
`else
    assign w_elig = 1'b1;
`endif

    assign w_accept     = (r_state == IDLE) && start_search;
    assign w_last_issue = (r_cls == LAST_CLASS) && (r_chunk == LAST_CHUNK);
    assign w_cand       = r_acc + dist_t'(r_pop);
    // Strict less-than keeps the lowest class index on ties.
    assign w_upd        = r_pop_vld && r_pop_last && w_elig && (w_cand < r_best_dist);
    assign busy         = (r_state == COMPARE) || (r_state == DRAIN);
    assign search_done  = (r_state == DONE);

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = start_search ? COMPARE : IDLE;
            COMPARE: w_next = w_last_issue ? DRAIN : COMPARE;
            DRAIN:   w_next = DONE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state         <= IDLE;
            r_query         <= '0;
            r_chunk         <= '0;
            r_cls           <= '0;
            r_pop           <= '0;
            r_pop_vld       <= 1'b0;
            r_pop_last      <= 1'b0;
            r_pop_cls       <= '0;
            r_acc           <= '0;
            r_best_dist     <= '0;
            r_best_cls      <= '0;
            predicted_class <= '0;
            min_distance    <= '0;
        end else if (en) begin
            r_state    <= w_next;
            r_pop_vld  <= (r_state == COMPARE);
            r_pop      <= w_pop;
            r_pop_last <= (r_chunk == LAST_CHUNK);
            r_pop_cls  <= r_cls;
            if (w_accept) begin
                r_query     <= query_hv;
                r_chunk     <= '0;
                r_cls       <= '0;
                r_acc       <= '0;
                r_best_dist <= '1;
                r_best_cls  <= '0;
            end
            if (r_state == COMPARE) begin
                r_chunk <= r_chunk + 1'b1;
                if (r_chunk == LAST_CHUNK) r_cls <= r_cls + 1'b1;
            end
            if (r_pop_vld) r_acc <= r_pop_last ? '0 : w_cand;
            if (w_upd) begin
                r_best_dist <= w_cand;
                r_best_cls  <= r_pop_cls;
            end
            // The last class resolves on the DRAIN edge, so results load with the bypassed winner.
            if (r_state == DRAIN) begin
                predicted_class <= w_upd ? r_pop_cls : r_best_cls;
                min_distance    <= w_upd ? w_cand : r_best_dist;
            end
        end
    end
endmodule

// File: tb/tb_class_hv_search.sv
// tb_class_hv_search: directed self-checking bench for class_hv_search (honours CLASS_MASK_EN).
module tb_class_hv_search;
    import hdc_pkg::*;
    logic clk = 1'b0, rst = 1'b1, en = 1'b1, start_search = 1'b0;
    logic [HV_DIM-1:0] query_hv = '0, q;
    logic [SEQ_CYCLE_COUNT-1:0][DIMS_PER_CC-1:0] cls [0:NUM_CLASSES-1];
    logic busy, search_done;
    logic [4:0] predicted_class;
    logic [DIST_W-1:0] min_distance;
`ifdef CLASS_MASK_EN
    logic [NUM_CLASSES-1:0] class_valid_mask = '1;
    logic no_valid_class;
`endif
    int n_chk = 0, n_fail = 0, lat, extra;

    always #5 clk = ~clk;

    class_hv_search dut (
        .clk              (clk),
        .rst              (rst),
        .en               (en),
        .start_search     (start_search),
        .query_hv         (query_hv),
        .bin_class_hvs    (cls),
`ifdef CLASS_MASK_EN
        .class_valid_mask (class_valid_mask),
        .no_valid_class   (no_valid_class),
`endif
        .busy             (busy),
        .search_done      (search_done),
        .predicted_class  (predicted_class),
        .min_distance     (min_distance)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic fill_random();
        logic [HV_DIM-1:0] t;
        for (int k = 0; k < NUM_CLASSES; k++) begin
            for (int w = 0; w < HV_DIM / 32; w++) t[w*32 +: 32] = $urandom;
            cls[k] = t;
        end
    endtask

    task automatic set_flipped(input int k, input int n, input logic [HV_DIM-1:0] base);
        logic [HV_DIM-1:0] t;
        t = base;
        for (int i = 0; i < n; i++) t[i*7] = ~t[i*7];
        cls[k] = t;
    endtask

    task automatic wait_done(input int low_at, input int low_len, input int dup_at, output int l);
        l = 1;
        while (!search_done && l < 400) begin
            start_search = (l == dup_at);
            if (l == low_at) en = 1'b0;
            if (l == low_at + low_len) en = 1'b1;
            @(negedge clk);
            l++;
        end
        start_search = 1'b0;
        en = 1'b1;
    endtask

    task automatic go(input int low_at, input int low_len, input int dup_at, output int l);
        query_hv = q;
        @(negedge clk) start_search = 1'b1;
        @(negedge clk) start_search = 1'b0;
        query_hv = ~q;
        wait_done(low_at, low_len, dup_at, l);
    endtask

    initial begin
        fill_random();
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", search_done, 0);
        chk("rst_class", predicted_class, 0);
        chk("rst_dist", min_distance, 0);
        rst = 1'b0;
        // exact match with class 7
        q = cls[7];
        go(0, 0, 0, lat);
        chk("a_latency", lat, 106);
        chk("a_class", predicted_class, 7);
        chk("a_dist", min_distance, 0);
        @(negedge clk);
        chk("a_done_pulse", search_done, 0);
        chk("a_hold_class", predicted_class, 7);
        // duplicate start at cycle 30 plus 10 disabled cycles
        go(40, 10, 30, lat);
        chk("d_latency", lat, 116);
        chk("d_class", predicted_class, 7);
        chk("d_dist", min_distance, 0);
        extra = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            extra += int'(search_done);
        end
        chk("d_single_done", extra, 0);
        chk("d_idle_busy", busy, 0);
        // classes 4 and 9 tie at zero distance
        fill_random();
        q = cls[4];
        cls[9] = q;
        go(0, 0, 0, lat);
        chk("c_latency", lat, 106);
        chk("c_class", predicted_class, 4);
        chk("c_dist", min_distance, 0);
        // start during DONE is ignored, then accepted in IDLE
        query_hv = q;
        start_search = 1'b1;
        @(negedge clk);
        chk("done_start_ignored", busy, 0);
        @(negedge clk);
        start_search = 1'b0;
        chk("idle_start_taken", busy, 1);
        wait_done(0, 0, 0, lat);
        chk("c2_latency", lat, 106);
        chk("c2_class", predicted_class, 4);
        // graded distances, class 12 nearest at 5
        for (int k = 0; k < NUM_CLASSES; k++) set_flipped(k, (k == 12) ? 5 : 200 + k, q);
        go(0, 0, 0, lat);
        chk("b_latency", lat, 106);
        chk("b_class", predicted_class, 12);
        chk("b_dist", min_distance, 5);
        // asynchronous reset at cycle 50 of a search
        query_hv = q;
        @(negedge clk) start_search = 1'b1;
        @(negedge clk) start_search = 1'b0;
        lat = 1;
        while (lat < 50) begin
            @(negedge clk);
            lat++;
        end
        chk("e_busy_mid", busy, 1);
        rst = 1'b1;
        #1;
        chk("e_rst_busy", busy, 0);
        chk("e_rst_class", predicted_class, 0);
        chk("e_rst_dist", min_distance, 0);
        @(negedge clk) rst = 1'b0;
        go(0, 0, 0, lat);
        chk("e_latency", lat, 106);
        chk("e_class", predicted_class, 12);
        chk("e_dist", min_distance, 5);
`ifdef CLASS_MASK_EN
        for (int k = 0; k < NUM_CLASSES; k++) set_flipped(k, (k == 3) ? 0 : (k == 20) ? 9 : 200 + k, q);
        class_valid_mask = '1;
        class_valid_mask[3] = 1'b0;
        go(0, 0, 0, lat);
        class_valid_mask = '1;
        chk("m_latency", lat, 106);
        chk("m_class", predicted_class, 20);
        chk("m_dist", min_distance, 9);
        chk("m_no_valid", no_valid_class, 0);
        @(negedge clk) class_valid_mask = '0;
        go(0, 0, 0, lat);
        class_valid_mask = '1;
        chk("z_latency", lat, 106);
        chk("z_class", predicted_class, 0);
        chk("z_dist", min_distance, 13'h1FFF);
        chk("z_no_valid", no_valid_class, 1);
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
